// File: rtl/axi_cmd_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : axi_cmd_slave
// Purpose  : AXI4-Lite byte-write slave that decodes register writes into a
//            command FIFO drained by the render core over valid/ready.
// Revision : 1.0
// ============================================================================
module axi_cmd_slave #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic [ADDR_WIDTH-1:0]        iAWADDR,
  input  logic [2:0]                   iAWPROT,
  input  logic                         iAWVALID,
  output logic                         iAWREADY,
  input  logic [DATA_WIDTH-1:0]        iWDATA,
  input  logic [DATA_WIDTH/8-1:0]      iWSTRB,
  input  logic                         iWVALID,
  output logic                         iWREADY,
  input  logic                         iBREADY,
  output logic [1:0]                   iBRESP,
  output logic                         iBVALID,
  output logic [DATA_WIDTH-1:0]        cmdData,
  output logic                         cmdValid,
  input  logic                         cmdReady,
  output logic [$clog2(FIFO_DEPTH):0]  fifoCount
);

  localparam int                    c_PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_PUSH = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_CTRL = ADDR_WIDTH'(2);
  localparam logic [1:0]            c_OKAY      = 2'b00;
  localparam logic [1:0]            c_SLVERR    = 2'b10;
  localparam logic [c_PTR_W:0]      c_FULL      = (c_PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_FIFO = 2'd1,
    ST_RESP      = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_aw_held;
  logic [ADDR_WIDTH-1:0]   r_aw_addr;
  logic                    r_w_held;
  logic [DATA_WIDTH-1:0]   r_w_data;
  logic [DATA_WIDTH/8-1:0] r_w_strb;
  logic                    r_bvalid;
  logic [1:0]              r_bresp;
  logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]      r_wr_ptr;
  logic [c_PTR_W-1:0]      r_rd_ptr;
  logic [c_PTR_W:0]        r_count;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_flush;
  logic                    w_set_resp;
  logic [1:0]              w_resp_code;
  logic                    w_clear_held;
  logic                    w_full;
  logic                    w_addr_push;
  logic                    w_addr_ctrl;
  logic                    w_strb_on;
  logic                    w_unused_prot;

  assign w_unused_prot = ^iAWPROT;

  assign w_full      = (r_count == c_FULL);
  assign w_addr_push = (r_aw_addr == c_ADDR_PUSH);
  assign w_addr_ctrl = (r_aw_addr == c_ADDR_CTRL);
  assign w_strb_on   = &r_w_strb;
  assign w_pop       = (r_count != '0) && cmdReady && !w_flush;

  assign iAWREADY  = ~r_aw_held;
  assign iWREADY   = ~r_w_held;
  assign iBVALID   = r_bvalid;
  assign iBRESP    = r_bresp;
  assign cmdValid  = (r_count != '0);
  assign cmdData   = r_mem[r_rd_ptr];
  assign fifoCount = r_count;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_push       = 1'b0;
    w_flush      = 1'b0;
    w_set_resp   = 1'b0;
    w_resp_code  = c_OKAY;
    w_clear_held = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_aw_held && r_w_held) begin
          if (w_addr_push && w_strb_on && w_full) begin
            w_state_nxt = ST_WAIT_FIFO;
          end else begin
            w_push      = w_addr_push && w_strb_on;
            w_flush     = w_addr_ctrl && w_strb_on && r_w_data[0];
            w_set_resp  = 1'b1;
            w_resp_code = (w_addr_push || w_addr_ctrl) ? c_OKAY : c_SLVERR;
            w_state_nxt = ST_RESP;
          end
        end
      end
      // Full status is registered, so the push lands the cycle after the freeing pop.
      ST_WAIT_FIFO: begin
        if (!w_full) begin
          w_push      = 1'b1;
          w_set_resp  = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (r_bvalid && iBREADY) begin
          w_clear_held = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_aw_held <= 1'b0;
      r_aw_addr <= '0;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= c_OKAY;
    end else begin
      if (iAWVALID && !r_aw_held) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= iAWADDR;
      end else if (w_clear_held) begin
        r_aw_held <= 1'b0;
      end
      if (iWVALID && !r_w_held) begin
        r_w_held <= 1'b1;
        r_w_data <= iWDATA;
        r_w_strb <= iWSTRB;
      end else if (w_clear_held) begin
        r_w_held <= 1'b0;
      end
      if (w_set_resp) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_resp_code;
      end else if (w_clear_held) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; contents are meaningless once the pointers clear.
  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_w_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_cmd_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axi_cmd_slave
// Purpose  : Scenario-driven self-checking bench with data/response scoreboards.
// Revision : 1.0
// ============================================================================
module tb_axi_cmd_slave;

  logic       ACLK = 1'b0;
  logic       ARESETn;
  logic [7:0] iAWADDR;
  logic [2:0] iAWPROT;
  logic       iAWVALID;
  logic       iAWREADY;
  logic [7:0] iWDATA;
  logic [0:0] iWSTRB;
  logic       iWVALID;
  logic       iWREADY;
  logic       iBREADY;
  logic [1:0] iBRESP;
  logic       iBVALID;
  logic [7:0] cmdData;
  logic       cmdValid;
  logic       cmdReady;
  logic [4:0] fifoCount;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [1:0] resp_q[$];

  always #5 ACLK = ~ACLK;

  axi_cmd_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .iAWADDR(iAWADDR), .iAWPROT(iAWPROT), .iAWVALID(iAWVALID), .iAWREADY(iAWREADY),
    .iWDATA(iWDATA), .iWSTRB(iWSTRB), .iWVALID(iWVALID), .iWREADY(iWREADY),
    .iBREADY(iBREADY), .iBRESP(iBRESP), .iBVALID(iBVALID),
    .cmdData(cmdData), .cmdValid(cmdValid), .cmdReady(cmdReady), .fifoCount(fifoCount)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  // Drives AW and W together, then waits for iBVALID without accepting it.
  task automatic axi_send(input logic [7:0] addr, input logic [7:0] data, input logic strb,
                          output logic [1:0] resp, output int lat);
    bit aw_done = 0, w_done = 0, aw_acc, w_acc, found = 0;
    iAWADDR = addr; iWDATA = data; iWSTRB = strb; iAWVALID = 1'b1; iWVALID = 1'b1;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      aw_acc = iAWVALID && iAWREADY;
      w_acc  = iWVALID && iWREADY;
      @(posedge ACLK); #1;
      if (aw_acc) begin aw_done = 1; iAWVALID = 1'b0; end
      if (w_acc)  begin w_done = 1;  iWVALID  = 1'b0; end
    end
    resp = 2'bxx; lat = 0;
    if (aw_done && w_done) begin
      for (int i = 0; i < 20 && !found; i++) begin
        if (iBVALID) begin found = 1; resp = iBRESP; end
        else begin @(posedge ACLK); #1; lat++; end
      end
    end
    if (!found) lat = -1;
  endtask

  task automatic b_ack();
    iBREADY = 1'b1;
    @(posedge ACLK); #1;
    iBREADY = 1'b0;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0; iAWADDR = '0; iAWPROT = '0; iAWVALID = 0; iWDATA = '0; iWSTRB = '0;
    iWVALID = 0; iBREADY = 0; cmdReady = 0;
    repeat (2) @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    n_checks++; if (iAWREADY !== 1'b1) begin n_fail++; $display("FAIL reset_awready: got %b want 1", iAWREADY); end
    n_checks++; if (iWREADY !== 1'b1) begin n_fail++; $display("FAIL reset_wready: got %b want 1", iWREADY); end
    n_checks++; if (iBVALID !== 1'b0) begin n_fail++; $display("FAIL reset_bvalid: got %b want 0", iBVALID); end
    n_checks++; if (iBRESP !== 2'b00) begin n_fail++; $display("FAIL reset_bresp: got %b want 00", iBRESP); end
    n_checks++; if (cmdValid !== 1'b0) begin n_fail++; $display("FAIL reset_cmdvalid: got %b want 0", cmdValid); end
    n_checks++; if (fifoCount !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifoCount); end
  endtask

  task automatic test_single_write();
    logic [1:0] r, er; int lat; logic [7:0] eb;
    exp_q.push_back(8'h45); resp_q.push_back(2'b00);
    axi_send(8'd1, 8'h45, 1'b1, r, lat);
    er = resp_q.pop_front();
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", lat); end
    n_checks++; if (r !== er) begin n_fail++; $display("FAIL single_bresp: got %b want %b", r, er); end
    n_checks++; if (cmdValid !== 1'b1) begin n_fail++; $display("FAIL single_cmdvalid: got %b want 1", cmdValid); end
    n_checks++; if (cmdData !== exp_q[0]) begin n_fail++; $display("FAIL single_cmddata: got %h want %h", cmdData, exp_q[0]); end
    n_checks++; if (fifoCount !== exp_q.size()) begin n_fail++; $display("FAIL single_count: got %0d want %0d", fifoCount, exp_q.size()); end
    b_ack();
    n_checks++; if (iAWREADY !== 1'b1 || iBVALID !== 1'b0) begin n_fail++; $display("FAIL single_ready_after_b: got aw=%b bv=%b want 1 0", iAWREADY, iBVALID); end
    eb = exp_q.pop_front();
    n_checks++; if (cmdData !== eb) begin n_fail++; $display("FAIL single_pop: got %h want %h", cmdData, eb); end
    cmdReady = 1'b1; @(posedge ACLK); #1; cmdReady = 1'b0;
    n_checks++; if (fifoCount !== 5'd0 || cmdValid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got count=%0d valid=%b want 0 0", fifoCount, cmdValid); end
  endtask

  task automatic test_full_backpressure();
    logic [1:0] r, er; int lat; logic [7:0] eb; bit found = 0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i)); resp_q.push_back(2'b00);
      axi_send(8'd1, 8'(i), 1'b1, r, lat);
      er = resp_q.pop_front();
      n_checks++; if (r !== er) begin n_fail++; $display("FAIL full_fill_bresp[%0d]: got %b want %b", i, r, er); end
      b_ack();
    end
    n_checks++; if (fifoCount !== 5'd16) begin n_fail++; $display("FAIL full_count16: got %0d want 16", fifoCount); end
    iAWADDR = 8'd1; iWDATA = 8'h10; iWSTRB = 1'b1; iAWVALID = 1'b1; iWVALID = 1'b1;
    @(posedge ACLK); #1;
    iAWVALID = 1'b0; iWVALID = 1'b0;
    exp_q.push_back(8'h10); resp_q.push_back(2'b00);
    n_checks++; if (iAWREADY !== 1'b0 || iWREADY !== 1'b0) begin n_fail++; $display("FAIL full_held: got aw=%b w=%b want 0 0", iAWREADY, iWREADY); end
    repeat (4) @(posedge ACLK); #1;
    n_checks++; if (iBVALID !== 1'b0) begin n_fail++; $display("FAIL full_stall_bvalid: got %b want 0", iBVALID); end
    eb = exp_q.pop_front();
    n_checks++; if (cmdData !== eb) begin n_fail++; $display("FAIL full_head_pop: got %h want %h", cmdData, eb); end
    cmdReady = 1'b1; @(posedge ACLK); #1; cmdReady = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      if (iBVALID) found = 1;
      else begin @(posedge ACLK); #1; end
    end
    er = resp_q.pop_front();
    n_checks++; if (!found) begin n_fail++; $display("FAIL full_resume_bvalid: got timeout want bvalid"); end
    n_checks++; if (iBRESP !== er) begin n_fail++; $display("FAIL full_resume_bresp: got %b want %b", iBRESP, er); end
    n_checks++; if (fifoCount !== exp_q.size()) begin n_fail++; $display("FAIL full_resume_count: got %0d want %0d", fifoCount, exp_q.size()); end
    n_checks++; if (cmdData !== exp_q[0]) begin n_fail++; $display("FAIL full_new_head: got %h want %h", cmdData, exp_q[0]); end
    b_ack();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      if (cmdValid) begin
        eb = exp_q.pop_front();
        n_checks++; if (cmdData !== eb) begin n_fail++; $display("FAIL full_drain: got %h want %h", cmdData, eb); end
        cmdReady = 1'b1; @(posedge ACLK); #1; cmdReady = 1'b0;
      end else begin
        @(posedge ACLK); #1;
      end
    end
    n_checks++; if (fifoCount !== 5'd0 || exp_q.size() != 0) begin n_fail++; $display("FAIL full_drain_empty: got count=%0d left=%0d want 0 0", fifoCount, exp_q.size()); end
  endtask

  task automatic test_unmapped_and_strb();
    logic [1:0] r, er; int lat; logic [7:0] eb;
    exp_q.push_back(8'h77); resp_q.push_back(2'b00);
    axi_send(8'd1, 8'h77, 1'b1, r, lat); b_ack();
    er = resp_q.pop_front();
    n_checks++; if (r !== er) begin n_fail++; $display("FAIL unmapped_prep_bresp: got %b want %b", r, er); end
    resp_q.push_back(2'b10);
    axi_send(8'd5, 8'hFF, 1'b1, r, lat);
    er = resp_q.pop_front();
    n_checks++; if (r !== er) begin n_fail++; $display("FAIL unmapped_bresp: got %b want %b", r, er); end
    n_checks++; if (fifoCount !== exp_q.size() || cmdValid !== 1'b1) begin n_fail++; $display("FAIL unmapped_fifo: got count=%0d valid=%b want %0d 1", fifoCount, cmdValid, exp_q.size()); end
    b_ack();
    resp_q.push_back(2'b00);
    axi_send(8'd1, 8'h99, 1'b0, r, lat);
    er = resp_q.pop_front();
    n_checks++; if (r !== er) begin n_fail++; $display("FAIL strb0_bresp: got %b want %b", r, er); end
    b_ack();
    n_checks++; if (fifoCount !== exp_q.size()) begin n_fail++; $display("FAIL strb0_count: got %0d want %0d", fifoCount, exp_q.size()); end
    eb = exp_q.pop_front();
    n_checks++; if (cmdData !== eb) begin n_fail++; $display("FAIL strb0_head: got %h want %h", cmdData, eb); end
    cmdReady = 1'b1; @(posedge ACLK); #1; cmdReady = 1'b0;
  endtask

  task automatic test_w_before_aw();
    logic [7:0] eb; bit found = 0; logic [1:0] er;
    iWDATA = 8'h30; iWSTRB = 1'b1; iWVALID = 1'b1;
    @(posedge ACLK); #1;
    iWVALID = 1'b0;
    n_checks++; if (iWREADY !== 1'b0) begin n_fail++; $display("FAIL wfirst_wready: got %b want 0", iWREADY); end
    repeat (2) @(posedge ACLK); #1;
    n_checks++; if (iBVALID !== 1'b0 || fifoCount !== 5'd0) begin n_fail++; $display("FAIL wfirst_wait: got bv=%b count=%0d want 0 0", iBVALID, fifoCount); end
    exp_q.push_back(8'h30); resp_q.push_back(2'b00);
    iAWADDR = 8'd1; iAWVALID = 1'b1;
    @(posedge ACLK); #1;
    iAWVALID = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      if (iBVALID) found = 1;
      else begin @(posedge ACLK); #1; end
    end
    er = resp_q.pop_front();
    n_checks++; if (!found || iBRESP !== er) begin n_fail++; $display("FAIL wfirst_bresp: got found=%b resp=%b want 1 %b", found, iBRESP, er); end
    b_ack();
    repeat (3) @(posedge ACLK); #1;
    n_checks++; if (iBVALID !== 1'b0 || fifoCount !== exp_q.size()) begin n_fail++; $display("FAIL wfirst_single: got bv=%b count=%0d want 0 %0d", iBVALID, fifoCount, exp_q.size()); end
    eb = exp_q.pop_front();
    n_checks++; if (cmdData !== eb) begin n_fail++; $display("FAIL wfirst_data: got %h want %h", cmdData, eb); end
    cmdReady = 1'b1; @(posedge ACLK); #1; cmdReady = 1'b0;
  endtask

  task automatic test_flush_with_pop();
    logic [1:0] r; int lat;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'hA0 + 8'(i));
      axi_send(8'd1, 8'hA0 + 8'(i), 1'b1, r, lat); b_ack();
    end
    n_checks++; if (fifoCount !== exp_q.size()) begin n_fail++; $display("FAIL flush_prefill: got %0d want %0d", fifoCount, exp_q.size()); end
    iAWADDR = 8'd2; iWDATA = 8'h01; iWSTRB = 1'b1; iAWVALID = 1'b1; iWVALID = 1'b1;
    @(posedge ACLK); #1;
    iAWVALID = 1'b0; iWVALID = 1'b0; cmdReady = 1'b1;
    @(posedge ACLK); #1;
    cmdReady = 1'b0;
    exp_q.delete();
    n_checks++; if (fifoCount !== 5'd0 || cmdValid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got count=%0d valid=%b want 0 0", fifoCount, cmdValid); end
    n_checks++; if (iBVALID !== 1'b1 || iBRESP !== 2'b00) begin n_fail++; $display("FAIL flush_bresp: got bv=%b resp=%b want 1 00", iBVALID, iBRESP); end
    b_ack();
  endtask

  task automatic test_async_reset();
    logic [1:0] r; int lat;
    axi_send(8'd1, 8'h99, 1'b1, r, lat);
    n_checks++; if (iBVALID !== 1'b1) begin n_fail++; $display("FAIL areset_pre_bvalid: got %b want 1", iBVALID); end
    #2 ARESETn = 1'b0;
    #1;
    n_checks++; if (iBVALID !== 1'b0) begin n_fail++; $display("FAIL areset_bvalid: got %b want 0", iBVALID); end
    n_checks++; if (iAWREADY !== 1'b1 || iWREADY !== 1'b1) begin n_fail++; $display("FAIL areset_ready: got aw=%b w=%b want 1 1", iAWREADY, iWREADY); end
    n_checks++; if (fifoCount !== 5'd0 || cmdValid !== 1'b0) begin n_fail++; $display("FAIL areset_fifo: got count=%0d valid=%b want 0 0", fifoCount, cmdValid); end
    exp_q.delete();
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_full_backpressure();
    test_unmapped_and_strb();
    test_w_before_aw();
    test_flush_with_pop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_cmd_slave.md
# axi_cmd_slave

AXI4-Lite write-slave front end of the Accelerator. Accepts byte-wide register writes from the host-side write master (the iAW/iW/iB channel set), decodes the address, and pushes command bytes (scene header, zoom, angle, object records) into a command FIFO. The render core drains the FIFO through a valid/ready stream. The block also generates the write response and applies back-pressure when the FIFO is full.

## Interface
Parameters:
- ADDR_WIDTH, 8, width of iAWADDR.
- DATA_WIDTH, 8, width of iWDATA. Fixed at 8; iWSTRB is DATA_WIDTH/8 = 1 bit.
- FIFO_DEPTH, 16, command FIFO entries. Power of two, ≥2.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETn  in  1  reset; one clock, asynchronous, active-low.
- iAWADDR  in  ADDR_WIDTH  write address.
- iAWPROT  in  3  protection; accepted and ignored.
- iAWVALID  in  1  address valid.
- iAWREADY  out  1  address ready.
- iWDATA  in  DATA_WIDTH  write data.
- iWSTRB  in  DATA_WIDTH/8  byte strobe.
- iWVALID  in  1  data valid.
- iWREADY  out  1  data ready.
- iBREADY  in  1  response ready.
- iBRESP  out  2  response code: 2'b00 OKAY, 2'b10 SLVERR.
- iBVALID  out  1  response valid.
- cmdData  out  8  FIFO head byte.
- cmdValid  out  1  FIFO not empty.
- cmdReady  in  1  render core consumes head byte.
- fifoCount  out  log2(FIFO_DEPTH)+1  current occupancy.

## Operation
- Address map:
  - 1 = CMD_PUSH: push iWDATA into the FIFO.
  - 2 = CTRL: if iWDATA[0]=1, flush the FIFO.
  - Any other address returns SLVERR and has no side effect.
- Holding registers:
  - awHeld/awAddr latch on iAWVALID&iAWREADY.
  - wHeld/wData/wStrb latch on iWVALID&iWREADY.
  - iAWREADY = ~awHeld. iWREADY = ~wHeld.
  - The AW and W channels are independent. Either may arrive first, or both may arrive in the same cycle.
- FSM states: IDLE, WAIT_FIFO, RESP.
  - IDLE: when awHeld&wHeld, commit the write.
    - If the target is CMD_PUSH, wStrb=1 and the FIFO is full, go to WAIT_FIFO.
    - Otherwise, perform the side effect (push, flush, or none), set iBVALID=1 with the decoded iBRESP, and go to RESP.
  - WAIT_FIFO: on the first cycle the FIFO is not full, push, set iBVALID=1 with OKAY, and go to RESP.
  - RESP: on iBVALID&iBREADY, clear iBVALID, awHeld and wHeld, and go to IDLE.
- wStrb=0 at a mapped address: no side effect, response OKAY.
- FIFO:
  - Circular buffer, FIFO_DEPTH entries. Read and write pointers wrap modulo FIFO_DEPTH.
  - cmdValid = (fifoCount≠0). cmdData = mem[rdPtr] (combinational read).
  - A pop occurs on cmdValid&cmdReady. cmdReady while empty is ignored.
  - Push and pop in the same cycle: both pointers advance and fifoCount is unchanged.
  - A push into a full FIFO never occurs (WAIT_FIFO prevents it).
  - Flush has priority over a simultaneous pop: both pointers and fifoCount go to 0.

## Timing
- Reset values:
  - iAWREADY=1, iWREADY=1, iBVALID=0, iBRESP=2'b00.
  - cmdValid=0, cmdData=mem[0] (don't-care), fifoCount=0.
  - FSM=IDLE, held flags=0, pointers=0.
- Best-case write latency:
  - Cycle 0: AW and W handshakes complete.
  - Cycle 1: commit in IDLE; the FIFO write and the count update occur at the edge ending cycle 1.
  - Cycle 2: iBVALID high, cmdValid high.
  - With iBREADY already high, the held flags clear after cycle 2. The earliest next AW/W accept is cycle 3.
- iAWREADY/iWREADY stay low from acceptance until the B handshake. This is correct even if the master holds iAWVALID high through RESP (no double capture).
- iBVALID, once high, stays high with a stable iBRESP until iBREADY.
- WAIT_FIFO: the commit happens in the cycle after the pop that frees space, so iBVALID rises 1 cycle after that pop.
- ARESETn low at any time, including mid-RESP or mid-WAIT_FIFO: outputs take their reset values immediately and asynchronously. The FIFO contents are lost.

## Test plan
- Write addr 1, data 0x45, strb 1, cmdReady=0 -> BRESP 00 with iBVALID at cycle 2, cmdValid=1, cmdData=0x45, fifoCount=1.
- 17 consecutive writes to addr 1 (data 0x00..0x10), cmdReady=0 -> first 16 get OKAY and fifoCount=16. 17th: iBVALID stays low. Then pulse cmdReady for 1 cycle -> head 0x00 popped, iBVALID rises 1 cycle later with OKAY, fifoCount=16, new head 0x01.
- Write addr 5, data 0xFF -> BRESP 2'b10, fifoCount unchanged, cmdValid unchanged.
- iWVALID with 0x30 presented 3 cycles before iAWVALID (addr 1) -> iWREADY low after the W accept. Exactly one push of 0x30 after AW arrives. One response.
- fifoCount=5, write addr 2 data 0x01 with cmdReady=1 in the same cycle -> fifoCount=0 and cmdValid=0 next cycle, BRESP OKAY.
- ARESETn driven low while iBVALID=1 -> iBVALID=0, iAWREADY=iWREADY=1, fifoCount=0 without waiting for a clock edge.
